sim_sram_arb: RTL and testbench

Arbiter and sequencer for the single-port simulation SRAM (prim_ram_1p, 1-cycle read latency). It shares the SRAM between NumReq requesters, such as the TL-UL SRAM adapter and a testbench/DMA backdoor port, using round-robin grant. It also runs a zero-fill initialisation sweep after reset or on demand. It sits between the requesters' req/gnt interfaces and the prim_ram_1p instance.

---
 rtl/sim_sram_arb.sv | 154 +++++++++++++++
 tb/tb_sim_sram_arb.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/sim_sram_arb.sv
// Round-robin arbiter and zero-fill sequencer in front of a single-port,
// 1-cycle-latency simulation SRAM.
module sim_sram_arb #(
   parameter int unsigned NumReq = 2,
   parameter int unsigned Width  = 32,
   parameter int unsigned Depth  = 8,
   localparam int unsigned AddrW = $clog2(Depth)
) (
   input  logic                      clk_i,
   input  logic                      rst_i,
   input  logic                      init_i,
   output logic                      init_done_o,
   input  logic [NumReq-1:0]         req_i,
   output logic [NumReq-1:0]         gnt_o,
   input  logic [NumReq-1:0]         we_i,
   input  logic [NumReq*AddrW-1:0]   addr_i,
   input  logic [NumReq*Width-1:0]   wdata_i,
   input  logic [NumReq*Width-1:0]   wmask_i,
   output logic [NumReq-1:0]         rvalid_o,
   output logic [Width-1:0]          rdata_o,
   output logic                      sram_req_o,
   output logic                      sram_we_o,
   output logic [AddrW-1:0]          sram_addr_o,
   output logic [Width-1:0]          sram_wdata_o,
   output logic [Width-1:0]          sram_wmask_o,
   input  logic [Width-1:0]          sram_rdata_i
);

   localparam int unsigned PtrW   = $clog2(NumReq);
   localparam int unsigned AddrW1 = AddrW + 1;
   localparam logic [AddrW-1:0] LastAddr  = AddrW'(Depth - 1);
   localparam logic [AddrW:0]   DepthExt  = AddrW1'(Depth);

   typedef enum logic [0:0] {
      ST_INIT = 1'b0,
      ST_RUN  = 1'b1
   } state_e;

   state_e            state_r;
   state_e            state_next_s;
   logic [AddrW-1:0]  cnt_r;
   logic              cnt_last_s;
   logic [PtrW-1:0]   ptr_r;
   logic [NumReq-1:0] gnt_s;
   logic [NumReq-1:0] rvalid_r;
   logic              win_found_s;
   logic [PtrW-1:0]   win_idx_s;
   int unsigned       idx_s;

   assign cnt_last_s = (cnt_r == LastAddr);

   // State register
   always_ff @(posedge clk_i) begin
      if (rst_i) state_r <= ST_INIT;
      else       state_r <= state_next_s;
   end

   // Next-state logic; init_i in either state (re)starts the sweep
   always_comb begin
      state_next_s = state_r;
      case (state_r)
         ST_INIT: begin
            if (init_i)          state_next_s = ST_INIT;
            else if (cnt_last_s) state_next_s = ST_RUN;
            else                 state_next_s = ST_INIT;
         end
         ST_RUN: begin
            if (init_i) state_next_s = ST_INIT;
            else        state_next_s = ST_RUN;
         end
         default: state_next_s = ST_INIT;
      endcase
   end

   // Sweep address counter, parked at zero outside an active sweep
   always_ff @(posedge clk_i) begin
      if (rst_i)                                            cnt_r <= '0;
      else if (state_r == ST_INIT && !init_i && !cnt_last_s) cnt_r <= cnt_r + AddrW'(1);
      else                                                  cnt_r <= '0;
   end

   // Round-robin search starting at the pointer
   always_comb begin
      win_found_s = 1'b0;
      win_idx_s   = '0;
      idx_s       = 0;
      for (int unsigned i = 0; i < NumReq; i++) begin
         idx_s = (32'(ptr_r) + i) % NumReq;
         if (!win_found_s && req_i[idx_s]) begin
            win_found_s = 1'b1;
            win_idx_s   = PtrW'(idx_s);
         end else begin
            win_idx_s   = win_idx_s;
         end
      end
   end

   // Grant and SRAM port mux; reset forces everything quiet
   always_comb begin
      gnt_s        = '0;
      sram_req_o   = 1'b0;
      sram_we_o    = 1'b0;
      sram_addr_o  = '0;
      sram_wdata_o = '0;
      sram_wmask_o = '0;
      if (rst_i) begin
         gnt_s = '0;
      end else if (state_r == ST_INIT) begin
         sram_req_o   = 1'b1;
         sram_we_o    = 1'b1;
         sram_addr_o  = cnt_r;
         sram_wmask_o = {Width{1'b1}};
      end else begin
         sram_req_o = |req_i;
         if (win_found_s) begin
            gnt_s[win_idx_s] = 1'b1;
            sram_we_o    = we_i[win_idx_s];
            sram_addr_o  = addr_i[win_idx_s*AddrW +: AddrW];
            sram_wdata_o = wdata_i[win_idx_s*Width +: Width];
            sram_wmask_o = wmask_i[win_idx_s*Width +: Width];
         end else begin
            sram_we_o = 1'b0;
         end
      end
   end

   // Pointer moves past the winner only when a grant is issued
   always_ff @(posedge clk_i) begin
      if (rst_i)                        ptr_r <= '0;
      else if (win_found_s && |gnt_s)   ptr_r <= PtrW'((32'(win_idx_s) + 1) % NumReq);
      else                              ptr_r <= ptr_r;
   end

   // Read-return flag, one cycle after a granted read
   always_ff @(posedge clk_i) begin
      if (rst_i) rvalid_r <= '0;
      else       rvalid_r <= gnt_s & ~we_i;
   end

   assign gnt_o       = gnt_s;
   assign rvalid_o    = rvalid_r;
   assign rdata_o     = sram_rdata_i;
   assign init_done_o = !rst_i && (state_r == ST_RUN);

   logic [AddrW:0] gnt_addr_ext_s;
   assign gnt_addr_ext_s = {1'b0, sram_addr_o};

   a_gnt_onehot0:    assert property (@(posedge clk_i) disable iff (rst_i) $onehot0(gnt_o));
   a_gnt_subset:     assert property (@(posedge clk_i) disable iff (rst_i) (gnt_o & ~req_i) == '0);
   a_rvalid_onehot0: assert property (@(posedge clk_i) disable iff (rst_i) $onehot0(rvalid_o));
   a_addr_range:     assert property (@(posedge clk_i) disable iff (rst_i)
                                      (|gnt_o) |-> (gnt_addr_ext_s < DepthExt));

endmodule

// File: tb/tb_sim_sram_arb.sv
// Scoreboard bench for sim_sram_arb: Depth=8 instance with an SRAM model,
// plus a Depth=5 instance to check the non-power-of-two sweep.
module tb_sim_sram_arb;

   logic clk;
   logic rst;

   // Depth=8 instance signals
   logic        init8;
   logic        done8;
   logic [1:0]  req8, gnt8, we8, rvalid8;
   logic [5:0]  addr8;
   logic [63:0] wdata8, wmask8;
   logic [31:0] rdata8;
   logic        s_req8, s_we8;
   logic [2:0]  s_addr8;
   logic [31:0] s_wdata8, s_wmask8, s_rdata8;

   // Depth=5 instance signals
   logic        init5;
   logic        done5;
   logic [1:0]  req5, gnt5, we5, rvalid5;
   logic [5:0]  addr5;
   logic [63:0] wdata5, wmask5;
   logic [31:0] rdata5;
   logic        s_req5, s_we5;
   logic [2:0]  s_addr5;
   logic [31:0] s_wdata5, s_wmask5, s_rdata5;

   typedef struct packed {
      logic [1:0]  v;
      logic [31:0] d;
   } exp_t;

   exp_t        sb_q[$];
   exp_t        e;
   int          n_chk  = 0;
   int          n_pass = 0;
   logic [31:0] mem [8];

   sim_sram_arb #(.NumReq(2), .Width(32), .Depth(8)) u_dut8 (
      .clk_i(clk), .rst_i(rst), .init_i(init8), .init_done_o(done8),
      .req_i(req8), .gnt_o(gnt8), .we_i(we8), .addr_i(addr8),
      .wdata_i(wdata8), .wmask_i(wmask8), .rvalid_o(rvalid8), .rdata_o(rdata8),
      .sram_req_o(s_req8), .sram_we_o(s_we8), .sram_addr_o(s_addr8),
      .sram_wdata_o(s_wdata8), .sram_wmask_o(s_wmask8), .sram_rdata_i(s_rdata8)
   );

   sim_sram_arb #(.NumReq(2), .Width(32), .Depth(5)) u_dut5 (
      .clk_i(clk), .rst_i(rst), .init_i(init5), .init_done_o(done5),
      .req_i(req5), .gnt_o(gnt5), .we_i(we5), .addr_i(addr5),
      .wdata_i(wdata5), .wmask_i(wmask5), .rvalid_o(rvalid5), .rdata_o(rdata5),
      .sram_req_o(s_req5), .sram_we_o(s_we5), .sram_addr_o(s_addr5),
      .sram_wdata_o(s_wdata5), .sram_wmask_o(s_wmask5), .sram_rdata_i(s_rdata5)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Single-port SRAM model with 1-cycle read latency and bit mask
   initial begin
      for (int i = 0; i < 8; i++) mem[i] = 32'hA5A5_0000 + i;
      s_rdata8 = 32'h0;
   end
   always @(posedge clk) begin
      if (s_req8) begin
         if (s_we8) mem[s_addr8] <= (mem[s_addr8] & ~s_wmask8) | (s_wdata8 & s_wmask8);
         else       s_rdata8 <= mem[s_addr8];
      end
   end

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic push(input logic [1:0] v, input logic [31:0] d);
      exp_t x;
      x.v = v;
      x.d = d;
      sb_q.push_back(x);
   endtask

   // Monitor: every rvalid must match the oldest expected read return
   initial begin
      forever begin
         @(negedge clk);
         if (rvalid8 !== 2'b00) begin
            if (sb_q.size() == 0) begin
               n_chk++;
               $display("FAIL rvalid_unexpected: actual=%0h required=0", rvalid8);
            end else begin
               e = sb_q.pop_front();
               chk("rvalid", {62'h0, rvalid8}, {62'h0, e.v});
               chk("rdata", {32'h0, rdata8}, {32'h0, e.d});
            end
         end
      end
   end

   initial begin
      #20000;
      $display("FAIL watchdog: actual=timeout required=finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      rst = 1'b1; init8 = 1'b0; req8 = 2'b00; we8 = 2'b00;
      addr8 = 6'h0; wdata8 = 64'h0; wmask8 = 64'h0;
      init5 = 1'b0; req5 = 2'b00; we5 = 2'b00; addr5 = 6'h0;
      wdata5 = 64'h0; wmask5 = 64'h0; s_rdata5 = 32'h0;

      @(negedge clk);
      chk("rst_sram_req", {63'h0, s_req8}, 64'h0);
      chk("rst_gnt", {62'h0, gnt8}, 64'h0);
      chk("rst_done", {63'h0, done8}, 64'h0);
      chk("rst_rvalid", {62'h0, rvalid8}, 64'h0);
      chk("rst_done5", {63'h0, done5}, 64'h0);

      // Release reset with both requesters already asking: they must wait
      step();
      rst = 1'b0; req8 = 2'b11; we8 = 2'b00; addr8 = {3'd5, 3'd2};
      for (int c = 0; c < 8; c++) begin
         @(negedge clk);
         chk("sweep_addr", {61'h0, s_addr8}, 64'(c));
         chk("sweep_we", {62'h0, s_req8, s_we8}, 64'h3);
         chk("sweep_wdata", {32'h0, s_wdata8}, 64'h0);
         chk("sweep_wmask", {32'h0, s_wmask8}, 64'hFFFF_FFFF);
         chk("sweep_gnt", {62'h0, gnt8}, 64'h0);
         chk("sweep_done", {63'h0, done8}, 64'h0);
         if (c < 5) begin
            chk("d5_addr", {61'h0, s_addr5}, 64'(c));
            chk("d5_we", {62'h0, s_req5, s_we5}, 64'h3);
            chk("d5_gnt", {62'h0, gnt5}, 64'h0);
         end else begin
            chk("d5_done", {63'h0, done5}, 64'h1);
            chk("d5_idle", {62'h0, s_req5, s_we5}, 64'h0);
            chk("d5_rvalid", {30'h0, rvalid5, rdata5}, 64'h0);
         end
      end

      // Four alternating reads of zero-filled locations
      for (int r = 0; r < 4; r++) begin
         @(negedge clk);
         chk("rr_gnt", {62'h0, gnt8}, (r % 2 == 0) ? 64'h1 : 64'h2);
         chk("rr_done", {63'h0, done8}, 64'h1);
         chk("rr_addr", {61'h0, s_addr8}, (r % 2 == 0) ? 64'h2 : 64'h5);
         push((r % 2 == 0) ? 2'b01 : 2'b10, 32'h0);
      end

      step();
      req8 = 2'b01; we8 = 2'b01; addr8 = {3'd0, 3'd3};
      wdata8 = {32'h0, 32'hDEAD_BEEF}; wmask8 = {32'h0, 32'hFFFF_0000};
      @(negedge clk);
      chk("wr_gnt", {62'h0, gnt8}, 64'h1);
      chk("wr_we", {62'h0, s_req8, s_we8}, 64'h3);
      chk("wr_addr", {61'h0, s_addr8}, 64'h3);
      chk("wr_wdata", {32'h0, s_wdata8}, 64'hDEAD_BEEF);
      chk("wr_wmask", {32'h0, s_wmask8}, 64'hFFFF_0000);

      step();
      req8 = 2'b10; we8 = 2'b00; addr8 = {3'd3, 3'd0};
      @(negedge clk);
      chk("rd_gnt", {62'h0, gnt8}, 64'h2);
      push(2'b10, 32'hDEAD_0000);

      step();
      req8 = 2'b00;
      @(negedge clk);
      chk("idle", {61'h0, s_req8, s_we8, |gnt8}, 64'h0);

      // Both write; the pointer (back at 0) favours requester 0 first
      step();
      req8 = 2'b11; we8 = 2'b11; addr8 = {3'd6, 3'd3};
      wdata8 = {32'h0000_CAFE, 32'h0000_1234}; wmask8 = 64'hFFFF_FFFF_FFFF_FFFF;
      @(negedge clk);
      chk("w2_gnt", {62'h0, gnt8}, 64'h1);
      chk("w2_addr", {61'h0, s_addr8}, 64'h3);
      @(negedge clk);
      chk("w3_gnt", {62'h0, gnt8}, 64'h2);
      chk("w3_addr", {61'h0, s_addr8}, 64'h6);
      chk("w3_wdata", {32'h0, s_wdata8}, 64'hCAFE);

      // init_i together with a read: the read still returns its data
      step();
      init8 = 1'b1; req8 = 2'b10; we8 = 2'b00; addr8 = {3'd3, 3'd0};
      @(negedge clk);
      chk("ini_gnt", {62'h0, gnt8}, 64'h2);
      chk("ini_done", {63'h0, done8}, 64'h1);
      push(2'b10, 32'h0000_1234);

      step();
      init8 = 1'b0;
      for (int c = 0; c < 8; c++) begin
         @(negedge clk);
         chk("s2_addr", {61'h0, s_addr8}, 64'(c));
         chk("s2_we", {62'h0, s_req8, s_we8}, 64'h3);
         chk("s2_gnt_done", {61'h0, gnt8, done8}, 64'h0);
      end
      @(negedge clk);
      chk("s2_rd_gnt", {62'h0, gnt8}, 64'h2);
      chk("s2_rd_done", {63'h0, done8}, 64'h1);
      push(2'b10, 32'h0);

      step();
      req8 = 2'b00;

      // Reset during RUN with a read pending
      step();
      rst = 1'b1; req8 = 2'b01; we8 = 2'b00; addr8 = 6'h0;
      @(negedge clk);
      chk("rs_gnt", {62'h0, gnt8}, 64'h0);
      chk("rs_req", {63'h0, s_req8}, 64'h0);
      chk("rs_done", {63'h0, done8}, 64'h0);

      step();
      rst = 1'b0; req8 = 2'b00;
      @(negedge clk);
      chk("rs_rvalid", {62'h0, rvalid8}, 64'h0);
      chk("rs_addr", {61'h0, s_addr8}, 64'h0);
      chk("rs_we", {62'h0, s_req8, s_we8}, 64'h3);
      @(negedge clk);
      chk("rs_addr1", {61'h0, s_addr8}, 64'h1);
      @(negedge clk);
      chk("rs_addr2", {61'h0, s_addr8}, 64'h2);

      // init_i mid-sweep restarts from address 0
      step();
      init8 = 1'b1;
      @(negedge clk);
      chk("rst_sweep_addr3", {61'h0, s_addr8}, 64'h3);
      step();
      init8 = 1'b0;
      @(negedge clk);
      chk("restart_addr0", {61'h0, s_addr8}, 64'h0);
      for (int c = 1; c < 8; c++) begin
         @(negedge clk);
         chk("restart_addr", {61'h0, s_addr8}, 64'(c));
         chk("restart_done", {63'h0, done8}, 64'h0);
      end
      @(negedge clk);
      chk("restart_run", {63'h0, done8}, 64'h1);

      step();
      chk("sb_empty", 64'(sb_q.size()), 64'h0);
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
